wb_cache: RTL and testbench

WB_CACHE -- requirements
Module: wb_cache

---
 rtl/cache_pkg.sv | 25 ++
 rtl/wb_cache_if.sv | 36 +++
 rtl/cache_array.sv | 57 +++++
 rtl/wb_cache.sv | 241 ++++++++++++++++++++++++
 tb/tb_wb_cache.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and derived geometry for the write-back cache
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    FL_SCAN,
    FL_WB
  } cache_state_t;

  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int line_width(input int data_w, input int offset_w);
    return data_w * (2 ** offset_w);
  endfunction

  function automatic int line_count(input int index_w);
    return 2 ** index_w;
  endfunction

endpackage

// File: rtl/wb_cache_if.sv
// rtl/wb_cache_if.sv - CPU byte port, flush handshake and line-memory port of wb_cache
interface wb_cache_if #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 2
) ();
  import cache_pkg::*;

  localparam int LINE_W = line_width(DATA_W, OFFSET_W);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              flush;
  logic              flush_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ack, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ack, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_array.sv
// rtl/cache_array.sv - tag/data/valid/dirty storage with one registered read port and one write port
module cache_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = 14,
  parameter int TAG_W   = 8,
  parameter int LINE_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line,
  input  logic               wr_valid,
  input  logic               wr_dirty
);

  localparam int LINES = line_count(INDEX_W);

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  // Tag/data behave like block RAM: no reset, read-before-write on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
    rd_tag  <= tag_mem[rd_idx];
    rd_line <= data_mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      rd_valid <= 1'b0;
      rd_dirty <= 1'b0;
    end else begin
      if (wr_en) begin
        valid_q[wr_idx] <= wr_valid;
        dirty_q[wr_idx] <= wr_dirty;
      end
      rd_valid <= valid_q[rd_idx];
      rd_dirty <= dirty_q[rd_idx];
    end
  end

endmodule

// File: rtl/wb_cache.sv
// rtl/wb_cache.sv - direct-mapped write-back, write-allocate byte cache with whole-cache flush
module wb_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 8,
  parameter int INDEX_W  = 14,
  parameter int OFFSET_W = 2
) (
  input logic       clk,
  input logic       reset,
  wb_cache_if.slave bus
);

  localparam int TAG_W  = tag_width(ADDR_W, INDEX_W, OFFSET_W);
  localparam int LINE_W = line_width(DATA_W, OFFSET_W);
  localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};

  cache_state_t        state;
  logic                lk_ph;
  logic                req_we;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic [DATA_W-1:0]   req_wdata;
  logic [INDEX_W-1:0]  scan_idx;

  logic                cpu_ack_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                flush_done_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;

  logic [INDEX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                rd_valid;
  logic                rd_dirty;
  logic                wr_en;
  logic [INDEX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]    wr_tag;
  logic [LINE_W-1:0]   wr_line;
  logic                wr_valid;
  logic                wr_dirty;

  logic                hit;
  logic [DATA_W-1:0]   sel_byte;
  logic [LINE_W-1:0]   upd_line;

  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.flush_done = flush_done_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  assign rd_idx   = (state == FL_SCAN || state == FL_WB) ? scan_idx : req_idx;
  assign hit      = rd_valid && (rd_tag == req_tag);
  assign sel_byte = rd_line[DATA_W*int'(req_off) +: DATA_W];

  always_comb begin
    upd_line = rd_line;
    upd_line[DATA_W*int'(req_off) +: DATA_W] = req_wdata;
  end

  // Array writes happen on the same edge as the FSM decision so a following re-read sees them.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = req_idx;
    wr_tag   = rd_tag;
    wr_line  = rd_line;
    wr_valid = rd_valid;
    wr_dirty = rd_dirty;
    case (state)
      LOOKUP: if (lk_ph && hit && req_we) begin
        wr_en    = 1'b1;
        wr_line  = upd_line;
        wr_valid = 1'b1;
        wr_dirty = 1'b1;
      end
      WB: if (mem_req_q && bus.mem_ack) begin
        wr_en    = 1'b1;
        wr_dirty = 1'b0;
      end
      FILL: if (mem_req_q && bus.mem_ack) begin
        wr_en    = 1'b1;
        wr_tag   = req_tag;
        wr_line  = bus.mem_rdata;
        wr_valid = 1'b1;
        wr_dirty = 1'b0;
      end
      FL_SCAN: if (lk_ph && !(rd_valid && rd_dirty)) begin
        wr_en    = 1'b1;
        wr_idx   = scan_idx;
        wr_valid = 1'b0;
        wr_dirty = 1'b0;
      end
      FL_WB: if (mem_req_q && bus.mem_ack) begin
        wr_en    = 1'b1;
        wr_idx   = scan_idx;
        wr_valid = 1'b0;
        wr_dirty = 1'b0;
      end
      default: ;
    endcase
  end

  cache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (rd_idx),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_line  (wr_line),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty)
  );

  // lk_ph marks that the registered array read for the current index has settled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lk_ph        <= 1'b0;
      req_we       <= 1'b0;
      req_tag      <= '0;
      req_idx      <= '0;
      req_off      <= '0;
      req_wdata    <= '0;
      scan_idx     <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      flush_done_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      cpu_ack_q    <= 1'b0;
      flush_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req && !cpu_ack_q) begin
            req_we    <= bus.cpu_we;
            req_tag   <= bus.cpu_addr[ADDR_W-1 -: TAG_W];
            req_idx   <= bus.cpu_addr[OFFSET_W +: INDEX_W];
            req_off   <= bus.cpu_addr[OFFSET_W-1:0];
            req_wdata <= bus.cpu_wdata;
            lk_ph     <= 1'b0;
            state     <= LOOKUP;
          end else if (bus.flush && !flush_done_q) begin
            scan_idx <= '0;
            lk_ph    <= 1'b0;
            state    <= FL_SCAN;
          end
        end
        LOOKUP: begin
          if (!lk_ph) begin
            lk_ph <= 1'b1;
          end else if (hit) begin
            cpu_ack_q <= 1'b1;
            if (!req_we) cpu_rdata_q <= sel_byte;
            state <= IDLE;
          end else if (rd_valid && rd_dirty) begin
            state <= WB;
          end else begin
            state <= FILL;
          end
        end
        WB: begin
          if (!mem_req_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {rd_tag, req_idx, {OFFSET_W{1'b0}}};
            mem_wdata_q <= rd_line;
          end else if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
          end else if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            lk_ph     <= 1'b0;
            state     <= LOOKUP;
          end
        end
        FL_SCAN: begin
          if (!lk_ph) begin
            lk_ph <= 1'b1;
          end else if (rd_valid && rd_dirty) begin
            state <= FL_WB;
          end else if (scan_idx == LAST_IDX) begin
            flush_done_q <= 1'b1;
            state        <= IDLE;
          end else begin
            scan_idx <= scan_idx + INDEX_W'(1);
            lk_ph    <= 1'b0;
          end
        end
        FL_WB: begin
          if (!mem_req_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {rd_tag, scan_idx, {OFFSET_W{1'b0}}};
            mem_wdata_q <= rd_line;
          end else if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (scan_idx == LAST_IDX) begin
              flush_done_q <= 1'b1;
              state        <= IDLE;
            end else begin
              scan_idx <= scan_idx + INDEX_W'(1);
              lk_ph    <= 1'b0;
              state    <= FL_SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cache.sv
// tb/tb_wb_cache.sv - directed self-checking bench for wb_cache
module tb_wb_cache;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  int          cnt;
  int          waited;
  logic        saw;
  logic [7:0]  rd;
  int          fl_cnt;
  int          wb_cnt;
  logic        fd;
  logic        ack_during;
  logic        fl_we;
  logic [23:0] fl_addr;
  logic [31:0] fl_wdata;

  wb_cache_if #(.ADDR_W(24), .DATA_W(8), .OFFSET_W(2)) bus ();

  wb_cache #(
    .ADDR_W   (24),
    .DATA_W   (8),
    .INDEX_W  (14),
    .OFFSET_W (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic we, input logic [23:0] addr, input logic [7:0] wdata);
    @(negedge clk);
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_req   = 1'b1;
  endtask

  task automatic wait_ack(output logic [7:0] rdata, output int n, output logic saw_mem);
    n = 0;
    saw_mem = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (bus.mem_req === 1'b1) saw_mem = 1'b1;
    end while (bus.cpu_ack !== 1'b1 && n < 200);
    chk("cpu_ack_seen", 64'(bus.cpu_ack), 64'h1);
    rdata = bus.cpu_rdata;
    bus.cpu_req = 1'b0;
  endtask

  task automatic mem_serve(input logic exp_we, input logic [23:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [31:0] rdata,
                           output int w);
    w = 0;
    while (bus.mem_req !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("mem_req_seen", 64'(bus.mem_req), 64'h1);
    if (bus.mem_req === 1'b1) begin
      chk("mem_we", 64'(bus.mem_we), 64'(exp_we));
      chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
      if (exp_we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
      @(negedge clk);
      chk("mem_addr_stable", 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, exp_addr}));
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("mem_req_drop", 64'(bus.mem_req), 64'h0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.flush     = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_ack", 64'(bus.cpu_ack), 64'h0);
    chk("rst_flush_done", 64'(bus.flush_done), 64'h0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'h0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'h0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'h0);
    chk("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'h0);

    // cold read miss: fill only, byte 2 of the returned line
    start_req(1'b0, 24'h123456, 8'h00);
    mem_serve(1'b0, 24'h123454, 32'h0, 32'hDDCCBBAA, waited);
    wait_ack(rd, cnt, saw);
    chk("miss_rdata", 64'(rd), 64'hCC);
    @(negedge clk);
    chk("rdata_hold_ack", 64'(bus.cpu_ack), 64'h0);
    chk("rdata_hold", 64'(bus.cpu_rdata), 64'hCC);

    // read hit in the same line
    start_req(1'b0, 24'h123457, 8'h00);
    wait_ack(rd, cnt, saw);
    chk("hit_latency", 64'(cnt), 64'd3);
    chk("hit_rdata", 64'(rd), 64'hDD);
    chk("hit_no_mem", 64'(saw), 64'h0);

    // write hit, then conflicting read forces write-back then fill
    start_req(1'b1, 24'h123455, 8'h5A);
    wait_ack(rd, cnt, saw);
    chk("whit_latency", 64'(cnt), 64'd3);
    chk("whit_no_mem", 64'(saw), 64'h0);
    start_req(1'b0, 24'h453454, 8'h00);
    mem_serve(1'b1, 24'h123454, 32'hDDCC5AAA, 32'h0, waited);
    mem_serve(1'b0, 24'h453454, 32'h0, 32'h44332211, waited);
    chk("wb_fill_gap", 64'(waited), 64'd1);
    wait_ack(rd, cnt, saw);
    chk("conflict_rdata", 64'(rd), 64'h11);

    // write miss allocates and dirties line 4
    start_req(1'b1, 24'h000010, 8'h77);
    mem_serve(1'b0, 24'h000010, 32'h0, 32'h00000000, waited);
    wait_ack(rd, cnt, saw);

    // cpu_req and flush together: access first, then one dirty write-back
    @(negedge clk);
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 24'h000010;
    bus.cpu_wdata = 8'h00;
    bus.cpu_req   = 1'b1;
    bus.flush     = 1'b1;
    wait_ack(rd, cnt, saw);
    chk("prio_rdata", 64'(rd), 64'h77);
    chk("prio_latency", 64'(cnt), 64'd3);
    chk("prio_no_flush_done", 64'(bus.flush_done), 64'h0);
    fl_cnt = 0;
    wb_cnt = 0;
    fd = 1'b0;
    ack_during = 1'b0;
    fl_we = 1'b0;
    fl_addr = '0;
    fl_wdata = '0;
    while (!fd && fl_cnt < 40000) begin
      @(negedge clk);
      fl_cnt++;
      bus.mem_ack = 1'b0;
      if (bus.cpu_ack === 1'b1) ack_during = 1'b1;
      if (bus.flush_done === 1'b1) begin
        fd = 1'b1;
      end else if (bus.mem_req === 1'b1) begin
        wb_cnt++;
        fl_we    = bus.mem_we;
        fl_addr  = bus.mem_addr;
        fl_wdata = bus.mem_wdata;
        bus.mem_ack = 1'b1;
      end
    end
    bus.flush = 1'b0;
    chk("flush_done_seen", 64'(fd), 64'h1);
    chk("flush_wb_count", 64'(wb_cnt), 64'd1);
    chk("flush_wb_we", 64'(fl_we), 64'h1);
    chk("flush_wb_addr", 64'(fl_addr), 64'h000010);
    chk("flush_wb_wdata", 64'(fl_wdata), 64'h00000077);
    chk("flush_no_cpu_ack", 64'(ack_during), 64'h0);
    @(negedge clk);
    chk("flush_done_pulse", 64'(bus.flush_done), 64'h0);

    // line was invalidated by the flush
    start_req(1'b0, 24'h000010, 8'h00);
    mem_serve(1'b0, 24'h000010, 32'h0, 32'h12345678, waited);
    wait_ack(rd, cnt, saw);
    chk("post_flush_rdata", 64'(rd), 64'h78);

    // reset while a fill is outstanding
    start_req(1'b0, 24'h123454, 8'h00);
    mem_serve(1'b0, 24'h123454, 32'h0, 32'hA1B2C3D4, waited);
    wait_ack(rd, cnt, saw);
    chk("pre_reset_rdata", 64'(rd), 64'hD4);
    start_req(1'b0, 24'h453454, 8'h00);
    waited = 0;
    while (bus.mem_req !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("fill_before_reset", 64'(bus.mem_req), 64'h1);
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("reset_mem_req", 64'(bus.mem_req), 64'h0);
    chk("reset_cpu_ack", 64'(bus.cpu_ack), 64'h0);
    reset = 1'b0;
    start_req(1'b0, 24'h123454, 8'h00);
    mem_serve(1'b0, 24'h123454, 32'h0, 32'h01020304, waited);
    wait_ack(rd, cnt, saw);
    chk("post_reset_rdata", 64'(rd), 64'h04);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
